// File: rtl/rr_enc_arbiter.sv
// rr_enc_arbiter
//   Round-robin arbiter for four requesters in front of an encoded-index
//   selector. It grants one requester at a time and reports the winner both
//   one-hot and as a 2-bit index. All outputs are registered.
//   A hold limit caps how long one owner may keep the resource. There is
//   always one idle cycle between consecutive grants.
//
// Parameters
//   HOLD_MAX : maximum consecutive grant cycles per grant, 0 = unlimited
//   CNT_W    : hold counter width, 2**CNT_W must exceed HOLD_MAX
//
// Ports
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   req     : request vector, req[i]=1 means requester i wants the resource
//   gnt     : one-hot grant (registered)
//   gnt_idx : encoded owner index, 0 when no grant is held (registered)
//   gnt_vld : high while a grant is held
//   preempt : one-cycle pulse on the idle cycle after a hold-limit release
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; arbitrate from ptr on the next edge if any req is set
// GRANT | owner gnt_idx holds the resource; release on drop or hold limit
module rr_enc_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit             UNLIMITED = (HOLD_MAX == 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       gnt_idx_nxt;
  logic             gnt_vld_nxt;
  logic             preempt_nxt;

  logic [3:0]       req_rot;
  logic [1:0]       win_off;
  logic [1:0]       win;
  logic             own_req;
  logic             hold_at_lim;

  // Rotate the request vector so that bit 0 is the requester at ptr.
  // A plain priority encode of the rotated vector then gives the offset
  // from ptr, and the 2-bit add wraps the offset back to an absolute index.
  always_comb begin
    req_rot = req;
    case (ptr)
      2'd0: req_rot = req;
      2'd1: req_rot = {req[0],   req[3:1]};
      2'd2: req_rot = {req[1:0], req[3:2]};
      2'd3: req_rot = {req[2:0], req[3]};
      default: req_rot = req;
    endcase
  end

  always_comb begin
    win_off = 2'd0;
    casez (req_rot)
      4'b???1: win_off = 2'd0;
      4'b??10: win_off = 2'd1;
      4'b?100: win_off = 2'd2;
      4'b1000: win_off = 2'd3;
      default: win_off = 2'd0;
    endcase
  end

  assign win         = ptr + win_off;
  assign own_req     = req[gnt_idx];
  assign hold_at_lim = !UNLIMITED && (hold_cnt == HOLD_LIM);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt;
    gnt_idx_nxt  = gnt_idx;
    gnt_vld_nxt  = gnt_vld;
    preempt_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = GRANT;
          gnt_nxt      = 4'b0001 << win;
          gnt_idx_nxt  = win;
          gnt_vld_nxt  = 1'b1;
          hold_cnt_nxt = CNT_ONE;
        end
      end

      GRANT: begin
        if (!own_req || hold_at_lim) begin
          // The releasing owner goes to the back of the queue. A forced
          // release is the only case where the owner still wants the
          // resource, so own_req doubles as the preempt flag.
          state_nxt    = IDLE;
          gnt_nxt      = 4'b0000;
          gnt_idx_nxt  = 2'd0;
          gnt_vld_nxt  = 1'b0;
          ptr_nxt      = gnt_idx + 2'd1;
          hold_cnt_nxt = '0;
          preempt_nxt  = own_req;
        end else begin
          // When limited, the counter never passes HOLD_LIM because the
          // release fires first. When unlimited, it parks at all-ones.
          if (hold_cnt != CNT_SAT) begin
            hold_cnt_nxt = hold_cnt + CNT_ONE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      gnt_vld  <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= gnt_idx_nxt;
      gnt_vld  <= gnt_vld_nxt;
      preempt  <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_enc_arbiter.sv
// Bench for rr_enc_arbiter. It drives two instances from the same stimulus:
// one limited to 8 cycles per grant and one unlimited. Both are compared
// every cycle against a behavioural model.
module tb_rr_enc_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       pre_a, pre_b;

  int errors = 0;
  int checks = 0;

  // Model state per instance: owner (-1 = none), cycles held, ptr, preempt.
  int m_own[2];
  int m_cnt[2];
  int m_ptr[2];
  bit m_pre[2];
  int hm[2] = '{8, 0};

  always #5 clk = ~clk;

  rr_enc_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .preempt(pre_a)
  );

  rr_enc_arbiter #(.HOLD_MAX(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .preempt(pre_b)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] rq);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_own[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0; m_pre[d] = 1'b0;
      end else if (m_own[d] < 0) begin
        m_pre[d] = 1'b0;
        if (rq != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr[d] + k) % 4;
            if (rq[c]) begin
              m_own[d] = c;
              m_cnt[d] = 1;
              break;
            end
          end
        end
      end else if (!rq[m_own[d]]) begin
        m_ptr[d] = (m_own[d] + 1) % 4;
        m_own[d] = -1;
        m_pre[d] = 1'b0;
      end else if (hm[d] != 0 && m_cnt[d] == hm[d]) begin
        m_ptr[d] = (m_own[d] + 1) % 4;
        m_own[d] = -1;
        m_pre[d] = 1'b1;
      end else begin
        m_cnt[d]++;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int d);
    return (m_own[d] < 0) ? 4'b0000 : 4'(1 << m_own[d]);
  endfunction

  function automatic logic [3:0] exp_idx(input int d);
    return (m_own[d] < 0) ? 4'd0 : 4'(m_own[d]);
  endfunction

  task automatic step(input logic r, input logic [3:0] rq);
    rst = r;
    req = rq;
    @(posedge clk);
    model_edge(r, rq);
    #1;
    chk("a.gnt",     gnt_a,          exp_gnt(0));
    chk("a.gnt_idx", {2'b00, idx_a}, exp_idx(0));
    chk("a.gnt_vld", {3'b000, vld_a}, {3'b000, (m_own[0] >= 0)});
    chk("a.preempt", {3'b000, pre_a}, {3'b000, m_pre[0]});
    chk("b.gnt",     gnt_b,          exp_gnt(1));
    chk("b.gnt_idx", {2'b00, idx_b}, exp_idx(1));
    chk("b.gnt_vld", {3'b000, vld_b}, {3'b000, (m_own[1] >= 0)});
    chk("b.preempt", {3'b000, pre_b}, {3'b000, m_pre[1]});
  endtask

  initial begin
    logic [3:0] rr;
    logic [1:0] order[5];
    logic [1:0] starts[$];
    logic       prev_vld;
    int         pre_cnt;
    int         hold_cnt_b;

    rst = 1'b1;
    req = 4'b0000;

    // Reset, then idle with no requests.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000);
    chk("idle_gnt", gnt_a, 4'b0000);

    // Requesters 1 and 3 with ptr=0: 1 wins; after 1 drops, one bubble, then 3.
    step(1'b0, 4'b1010);
    chk("p2_first_gnt", gnt_a, 4'b0010);
    chk("p2_first_idx", {2'b00, idx_a}, 4'd1);
    step(1'b0, 4'b1010);
    step(1'b0, 4'b1010);
    step(1'b0, 4'b1000);
    chk("p2_bubble_vld", {3'b000, vld_a}, 4'd0);
    step(1'b0, 4'b1000);
    chk("p2_second_gnt", gnt_a, 4'b1000);
    chk("p2_second_idx", {2'b00, idx_a}, 4'd3);
    step(1'b0, 4'b0000);

    // All request continuously: limited instance rotates 0,1,2,3,0.
    step(1'b1, 4'b0000);
    prev_vld = 1'b0;
    pre_cnt  = 0;
    starts.delete();
    for (int i = 0; i < 44; i++) begin
      step(1'b0, 4'b1111);
      if (vld_a && !prev_vld) starts.push_back(idx_a);
      if (pre_a) pre_cnt++;
      prev_vld = vld_a;
    end
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    chk("p3_num_grants", 4'(starts.size()), 4'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < starts.size()) chk($sformatf("p3_order[%0d]", i), {2'b00, starts[i]}, {2'b00, order[i]});
    end
    chk("p3_preempts", 4'(pre_cnt), 4'd4);

    // Unlimited instance keeps a lone requester indefinitely.
    step(1'b1, 4'b0000);
    pre_cnt    = 0;
    hold_cnt_b = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 4'b0100);
      if (gnt_b == 4'b0100) hold_cnt_b++;
      if (pre_b) pre_cnt++;
    end
    chk("p4_b_hold_cycles", 8'(hold_cnt_b) > 8'd49 ? 4'd1 : 4'd0, 4'd1);
    chk("p4_b_preempts", 4'(pre_cnt), 4'd0);

    // Reset during a grant on idx 2 drops it and returns ptr to 0.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    chk("p5_gnt_before", gnt_a, 4'b0100);
    step(1'b1, 4'b1111);
    chk("p5_gnt_after_rst", gnt_a, 4'b0000);
    step(1'b0, 4'b1111);
    chk("p5_first_idx", {2'b00, idx_a}, 4'd0);

    // Rotation after voluntary releases.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0011);
    chk("p6_idx_after_1", {2'b00, idx_a}, 4'd0);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0011);
    chk("p6_idx_after_0", {2'b00, idx_a}, 4'd1);

    // Random traffic with occasional resets.
    rr = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) rr[b] = ~rr[b];
      end
      step($urandom_range(60) == 0, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
